// File: rtl/bcd_div_pkg.sv
// Shared constants and bounded-subtract residue helpers for the BCD divisibility checker.
package bcd_div_pkg;
   localparam int BCD_W    = 4;
   localparam int N_DIGITS = 4;
   localparam int BCD_MAX  = 9;
   localparam int MOD3     = 3;
   localparam int MOD11    = 11;
   localparam int S_W      = 6;

   // Input range 0..36; each step removes a multiple of 3 without underflow.
   function automatic logic [1:0] mod3_res(input logic [S_W-1:0] s);
      logic [S_W-1:0] t;
      t = s;
      if (t >= S_W'(8*MOD3)) t = t - S_W'(8*MOD3);
      if (t >= S_W'(4*MOD3)) t = t - S_W'(4*MOD3);
      if (t >= S_W'(2*MOD3)) t = t - S_W'(2*MOD3);
      if (t >= S_W'(MOD3))   t = t - S_W'(MOD3);
      return t[1:0];
   endfunction

   // Input is the biased alternating sum, range 4..40.
   function automatic logic [3:0] mod11_res(input logic [S_W-1:0] s);
      logic [S_W-1:0] t;
      t = s;
      if (t >= S_W'(2*MOD11)) t = t - S_W'(2*MOD11);
      if (t >= S_W'(MOD11))   t = t - S_W'(MOD11);
      return t[3:0];
   endfunction
endpackage

// File: rtl/bcd_div3_div11_if.sv
// Operand/result bundle for the BCD divisibility checker.
interface bcd_div3_div11_if;
   logic a00, a01, a02, a03;
   logic a10, a11, a12, a13;
   logic a20, a21, a22, a23;
   logic a30, a31, a32, a33;
   logic div_11_n3;
   logic o;

   modport master (
      output a00, a01, a02, a03, a10, a11, a12, a13,
             a20, a21, a22, a23, a30, a31, a32, a33, div_11_n3,
      input  o
   );
   modport slave (
      input  a00, a01, a02, a03, a10, a11, a12, a13,
             a20, a21, a22, a23, a30, a31, a32, a33, div_11_n3,
      output o
   );
endinterface

// File: rtl/bcd_residue.sv
// Combinational residue datapath: digit validity plus zero-residue flags for 3 and 11.
module bcd_residue
   import bcd_div_pkg::*;
(
   input  logic [N_DIGITS-1:0][BCD_W-1:0] d,
   output logic                           digit_ok,
   output logic                           zero_mod3,
   output logic                           zero_mod11
);
   logic [N_DIGITS-1:0] dig_ok;
   logic [S_W-2:0]      s_even, s_odd;
   logic [S_W-1:0]      s3, s11b;

   for (genvar i = 0; i < N_DIGITS; i++) begin : g_ok
      assign dig_ok[i] = (d[i] <= BCD_W'(BCD_MAX));
   end
   assign digit_ok = &dig_ok;

   assign s_even = {1'b0, d[0]} + {1'b0, d[2]};
   assign s_odd  = {1'b0, d[1]} + {1'b0, d[3]};
   assign s3     = {1'b0, s_even} + {1'b0, s_odd};
   // Bias by 22 so the alternating sum (-18..18) stays positive in 6 bits.
   assign s11b   = {1'b0, s_even} + S_W'(2*MOD11) - {1'b0, s_odd};

   assign zero_mod3  = (mod3_res(s3) == 2'd0);
   assign zero_mod11 = (mod11_res(s11b) == 4'd0);
endmodule

// File: rtl/bcd_div3_div11.sv
// 4-digit packed-BCD divisibility checker (by 3 or 11), one registered output.
module bcd_div3_div11
   import bcd_div_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   bcd_div3_div11_if.slave bus
);
   logic [N_DIGITS-1:0][BCD_W-1:0] d;
   logic digit_ok, zero_mod3, zero_mod11, result, o_q;

   assign d[0] = {bus.a03, bus.a02, bus.a01, bus.a00};
   assign d[1] = {bus.a13, bus.a12, bus.a11, bus.a10};
   assign d[2] = {bus.a23, bus.a22, bus.a21, bus.a20};
   assign d[3] = {bus.a33, bus.a32, bus.a31, bus.a30};

   bcd_residue u_res (
      .d          (d),
      .digit_ok   (digit_ok),
      .zero_mod3  (zero_mod3),
      .zero_mod11 (zero_mod11)
   );

   // Any non-BCD digit vetoes the result in both modes.
   assign result = digit_ok & (bus.div_11_n3 ? zero_mod11 : zero_mod3);

   always_ff @(posedge clk) begin
      if (rst) o_q <= 1'b0;
      else     o_q <= result;
   end

   assign bus.o = o_q;
endmodule

// File: tb/tb_bcd_div3_div11.sv
// Scoreboard bench: driver pushes expected o per edge, monitor pops and compares.
module tb_bcd_div3_div11;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   logic exp_q[$];
   string name_q[$];

   bcd_div3_div11_if bus();
   bcd_div3_div11 dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic drv(input logic [15:0] n, input logic m, input logic r,
                      input logic e, input string nm);
      @(negedge clk);
      {bus.a03, bus.a02, bus.a01, bus.a00} = n[3:0];
      {bus.a13, bus.a12, bus.a11, bus.a10} = n[7:4];
      {bus.a23, bus.a22, bus.a21, bus.a20} = n[11:8];
      {bus.a33, bus.a32, bus.a31, bus.a30} = n[15:12];
      bus.div_11_n3 = m;
      rst = r;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   function automatic logic [15:0] to_bcd(input int n);
      return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   // Monitor: each edge's result is visible 1 time unit later.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         logic  e;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         n_chk++;
         if (bus.o !== e) begin
            n_fail++;
            $display("FAIL %s: o=%b expected %b", nm, bus.o, e);
         end
      end
   end

   typedef struct { logic [15:0] n; logic m; logic e; string nm; } vec_t;
   vec_t vecs[$];

   initial begin
      {bus.a00, bus.a01, bus.a02, bus.a03, bus.a10, bus.a11, bus.a12, bus.a13,
       bus.a20, bus.a21, bus.a22, bus.a23, bus.a30, bus.a31, bus.a32, bus.a33} = '0;
      bus.div_11_n3 = 1'b0;

      // Reset with operands that would otherwise yield 1.
      drv(16'h3234, 1'b0, 1'b1, 1'b0, "reset0");
      drv(16'h0000, 1'b1, 1'b1, 1'b0, "reset1");
      drv(16'h3234, 1'b0, 1'b0, 1'b1, "first_after_reset");

      vecs = '{
         '{16'h3235, 1'b0, 1'b0, "3235_m0"}, '{16'h3235, 1'b1, 1'b0, "3235_m1"},
         '{16'h3234, 1'b0, 1'b1, "3234_m0"}, '{16'h3234, 1'b1, 1'b1, "3234_m1"},
         '{16'h9899, 1'b0, 1'b0, "9899_m0"}, '{16'h9899, 1'b1, 1'b0, "9899_m1"},
         '{16'h8558, 1'b1, 1'b1, "8558_m1"}, '{16'h8382, 1'b1, 1'b1, "8382_m1"},
         '{16'h9999, 1'b1, 1'b1, "9999_m1"}, '{16'h0000, 1'b1, 1'b1, "0000_m1"},
         '{16'h1001, 1'b1, 1'b1, "1001_m1"}, '{16'h9898, 1'b1, 1'b0, "9898_m1"},
         '{16'h9999, 1'b0, 1'b1, "9999_m0"}, '{16'h0000, 1'b0, 1'b1, "0000_m0"},
         '{16'h0001, 1'b0, 1'b0, "0001_m0"},
         '{16'h0033, 1'b0, 1'b1, "0033_m0"}, '{16'h0033, 1'b1, 1'b1, "0033_m1"},
         '{16'h0033, 1'b0, 1'b1, "0033_m0b"}, '{16'h0010, 1'b1, 1'b0, "0010_m1"},
         '{16'h0012, 1'b0, 1'b1, "0012_m0"}, '{16'h0011, 1'b1, 1'b1, "0011_m1"},
         '{16'h000A, 1'b0, 1'b0, "bad_d0_m0"}, '{16'h000A, 1'b1, 1'b0, "bad_d0_m1"},
         '{16'hF000, 1'b0, 1'b0, "bad_d3_m0"}, '{16'hF000, 1'b1, 1'b0, "bad_d3_m1"},
         '{16'h0C00, 1'b0, 1'b0, "bad_d2_m0"}, '{16'h0C00, 1'b1, 1'b0, "bad_d2_m1"}
      };
      foreach (vecs[i]) drv(vecs[i].n, vecs[i].m, 1'b0, vecs[i].e, vecs[i].nm);

      // Exhaustive sweep against an arithmetic reference, one mid-stream reset.
      for (int m = 0; m < 2; m++) begin
         for (int n = 0; n < 10000; n++) begin
            logic e, r;
            r = (m == 1 && n == 5000);
            e = r ? 1'b0 : ((m == 1) ? (n % 11 == 0) : (n % 3 == 0));
            drv(to_bcd(n), m[0], r, e, r ? "midstream_reset" : "sweep");
         end
      end

      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
